// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and binary owner index.
// Optional macro HOLD_TIMEOUT_EN enables forced release after MAX_HOLD cycles of contention.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       preempt
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t     r_state;
   logic [2:0] r_ptr;
   logic [7:0] r_gnt;
   logic [2:0] r_idx;
   logic       r_valid;

   logic [7:0] w_cand;
   logic [2:0] w_start;
   logic [7:0] w_rot;
   logic [2:0] w_pos;
   logic       w_found;
   logic [2:0] w_win;
   logic [7:0] w_win_oh;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
      $error("rr_arbiter8: MAX_HOLD must be in 1..255");
   end

   // The owner is masked out, so one search serves idle start, release and forced release.
   assign w_cand  = req & ~r_gnt;
   assign w_start = (r_state == S_GRANT) ? r_idx + 3'd1 : r_ptr;

   for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign w_rot[gi] = w_cand[w_start + 3'(gi)];
   end

   always_comb begin
      w_pos   = '0;
      w_found = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_pos   = 3'(k);
            w_found = 1'b1;
         end
      end
   end

   assign w_win    = w_start + w_pos;
   assign w_win_oh = 8'b1 << w_win;

`ifdef HOLD_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
   logic [7:0] r_cnt;
   logic       r_preempt;
   logic       w_expire;
   assign w_expire = (r_cnt == HOLD_LAST) && w_found;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
         r_cnt     <= '0;
         r_preempt <= 1'b0;
`endif
      end else begin
`ifdef HOLD_TIMEOUT_EN
         r_preempt <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_gnt   <= w_win_oh;
                  r_idx   <= w_win;
                  r_valid <= 1'b1;
`ifdef HOLD_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_GRANT: begin
               if (!req[r_idx]) begin
                  r_ptr <= r_idx + 3'd1;
`ifdef HOLD_TIMEOUT_EN
                  r_cnt <= '0;
`endif
                  if (w_found) begin
                     r_gnt <= w_win_oh;
                     r_idx <= w_win;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= '0;
                     r_idx   <= '0;
                     r_valid <= 1'b0;
                  end
               end
`ifdef HOLD_TIMEOUT_EN
               else if (w_expire) begin
                  r_ptr     <= r_idx + 3'd1;
                  r_gnt     <= w_win_oh;
                  r_idx     <= w_win;
                  r_preempt <= 1'b1;
                  r_cnt     <= '0;
               end else if (r_cnt != HOLD_LAST) begin
                  // Saturate so a late competitor triggers release at once.
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = r_idx;
   assign gnt_valid = r_valid;
`ifdef HOLD_TIMEOUT_EN
   assign preempt   = r_preempt;
`else
   assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed literal checks plus a randomized run against a queue-free
// behavioural model (owner number, pointer, hold count) checked every falling edge.
module tb_rr_arbiter8;
   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       preempt;

   int total = 0;
   int bad   = 0;

   rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   // Behavioural model: owner is -1 when nobody holds the resource.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   bit m_pre   = 1'b0;

   function automatic int pick(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0; m_pre = 1'b0;
      end else begin
         logic [7:0] others;
         m_pre = 1'b0;
         if (m_owner < 0) begin
            if (req != 8'h00) begin
               m_owner = pick(req, m_ptr);
               m_cnt   = 0;
            end
         end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = pick(req, m_ptr);
            m_cnt   = 0;
         end else begin
            others = req & ~(8'h01 << m_owner);
`ifdef HOLD_TIMEOUT_EN
            if (m_cnt == MAX_HOLD - 1 && others != 8'h00) begin
               m_ptr   = (m_owner + 1) % 8;
               m_owner = pick(others, m_ptr);
               m_pre   = 1'b1;
               m_cnt   = 0;
            end else if (m_cnt < MAX_HOLD - 1) begin
               m_cnt++;
            end
`else
            if (others == 8'hFF) m_cnt = 0;
`endif
         end
      end
   end

   function automatic logic [12:0] model_out();
      logic [7:0] g;
      logic [2:0] i;
      g = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      i = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      return {g, i, (m_owner >= 0), m_pre};
   endfunction

   // Every-cycle compare against the model plus the one-hot invariant.
   always @(negedge clk) begin
      logic [12:0] e;
      e = model_out();
      total++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== e) begin
         bad++;
         $display("FAIL model t=%0t got gnt=%b idx=%0d v=%b p=%b want gnt=%b idx=%0d v=%b p=%b",
                  $time, gnt, gnt_idx, gnt_valid, preempt, e[12:5], e[4:2], e[1], e[0]);
      end
      total++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt) || (gnt_valid && gnt !== (8'h01 << gnt_idx))) begin
         bad++;
         $display("FAIL onehot t=%0t got gnt=%b idx=%0d v=%b want onehot gnt matching idx/valid",
                  $time, gnt, gnt_idx, gnt_valid);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Literal check of DUT and model together.
   task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] i,
                      input logic v, input logic p);
      logic [12:0] e;
      e = model_out();
      total++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== {g, i, v, p}) begin
         bad++;
         $display("FAIL %s got gnt=%b idx=%0d v=%b p=%b want gnt=%b idx=%0d v=%b p=%b",
                  nm, gnt, gnt_idx, gnt_valid, preempt, g, i, v, p);
      end else begin
         $display("ok   %s req=%b gnt=%b idx=%0d v=%b p=%b", nm, req, gnt, gnt_idx, gnt_valid, preempt);
      end
      total++;
      if (e !== {g, i, v, p}) begin
         bad++;
         $display("FAIL %s_model got %b want %b", nm, e, {g, i, v, p});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] eg;
      int o;

      // Reset with all requests pending
      req = 8'hFF;
      repeat (3) step();
      chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

      // Single requester
      do_reset();
      req = 8'b0000_0100;
      step();
      chk("single", 8'h04, 3'd2, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("single_hold", 8'h04, 3'd2, 1'b1, 1'b0);
      end
      req = 8'h00;
      step();
      chk("single_drop", 8'h00, 3'd0, 1'b0, 1'b0);

      // Rotation with no idle cycle
      do_reset();
      req = 8'hFF;
      step();
      chk("rot_start", 8'h01, 3'd0, 1'b1, 1'b0);
      o = 0;
      for (int k = 1; k <= 8; k++) begin
         r = 8'hFF;
         r[o] = 1'b0;
         req = r;
         step();
         eg = 8'h01 << (k % 8);
         chk("rot", eg, 3'(k % 8), 1'b1, 1'b0);
         req = 8'hFF;
         step();
         chk("rot_hold", eg, 3'(k % 8), 1'b1, 1'b0);
         o = k % 8;
      end

      // Wrap-around from owner 6
      do_reset();
      req = 8'b0100_0000;
      step();
      chk("wrap_own6", 8'h40, 3'd6, 1'b1, 1'b0);
      req = 8'b0000_0011;
      step();
      chk("wrap", 8'h01, 3'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a grant
      do_reset();
      req = 8'b0010_0000;
      step();
      chk("async_own5", 8'h20, 3'd5, 1'b1, 1'b0);
      #1 rst = 1'b1;
      #1 chk("async_drop", 8'h00, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      req = 8'b0010_0010;
      step();
      chk("async_after", 8'h02, 3'd1, 1'b1, 1'b0);

      // Hold behaviour with two contenders
      do_reset();
      req = 8'b0001_0001;
      step();
      chk("hold_start", 8'h01, 3'd0, 1'b1, 1'b0);
`ifdef HOLD_TIMEOUT_EN
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_hold0", 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step();
      chk("to_pre4", 8'h10, 3'd4, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_hold4", 8'h10, 3'd4, 1'b1, 1'b0);
      end
      step();
      chk("to_pre0", 8'h01, 3'd0, 1'b1, 1'b1);
      req = 8'b0000_0001;
`endif
      for (int k = 0; k < 10; k++) begin
         step();
         chk("hold_forever", 8'h01, 3'd0, 1'b1, 1'b0);
      end

      // Randomized run with sticky requests and occasional async resets
      do_reset();
      r = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         end
         req = r;
         if ($urandom_range(0, 299) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
